// File: rtl/block_data_memory.sv
// -----------------------------------------------------------------------------
// block_data_memory
//
// Backing store behind the data cache. Serves one 128-bit block read or write
// per request after a fixed LATENCY, holding mem_BusyWait high until the
// transfer has completed. A completed transfer is signalled by a single cycle
// of mem_BusyWait low (COMPLETE), after which the block returns to IDLE.
//
// Parameters:
//   DEPTH_BITS : block-index bits; array holds 2**DEPTH_BITS x 128-bit blocks
//   LATENCY    : cycles from request acceptance to completion (1..15)
//
// Ports:
//   clock         in   1    rising-edge clock
//   reset         in   1    asynchronous, active-low reset
//   mem_Read      in   1    block read request, held until busy falls
//   mem_Write     in   1    block write request, held until busy falls
//   mem_Address   in   28   block address (byte address [31:4])
//   mem_Writedata in   128  write block, stable while mem_Write is high
//   mem_Readdata  out  128  read block, registered, changes only at read completion
//   mem_BusyWait  out  1    high while a transfer is in flight
// -----------------------------------------------------------------------------
module block_data_memory #(
   parameter int DEPTH_BITS = 8,
   parameter int LATENCY    = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         mem_Read,
   input  logic         mem_Write,
   input  logic [27:0]  mem_Address,
   input  logic [127:0] mem_Writedata,
   output logic [127:0] mem_Readdata,
   output logic         mem_BusyWait
);

   localparam int         DEPTH    = 2 ** DEPTH_BITS;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_COMPLETE
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   op_write_q, op_write_d;
   logic [DEPTH_BITS-1:0]  idx_q, idx_d;
   logic [127:0]           wdata_q, wdata_d;
   logic [127:0]           rdata_q, rdata_d;
   logic                   mem_we;

   logic [127:0]           mem_array [DEPTH];

   // Upper address bits alias onto the same blocks and are deliberately ignored.
   generate
      if (DEPTH_BITS < 28) begin : g_alias
         logic unused_addr_bits;
         assign unused_addr_bits = ^mem_Address[27:DEPTH_BITS];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Next-state / datapath
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_write_d = op_write_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      mem_we     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_Read || mem_Write) begin
               state_d    = ST_BUSY;
               cnt_d      = CNT_LOAD;
               // A simultaneous read+write is treated as a write.
               op_write_d = mem_Write;
               idx_d      = mem_Address[DEPTH_BITS-1:0];
               wdata_d    = mem_Writedata;
            end
         end
         ST_BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_COMPLETE;
               if (op_write_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d = mem_array[idx_q];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_COMPLETE: begin
            // Any request still high here belongs to the finished transfer.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control and data registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         op_write_q <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_write_q <= op_write_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   // Array is not reset. An aborted write never commits because reset drops
   // the state out of BUSY before the completion edge.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_array[idx_q] <= wdata_q;
      end
   end

   // Busy rises combinationally with a request seen in IDLE.
   assign mem_BusyWait = reset &&
                         ((state_q == ST_BUSY) ||
                          ((state_q == ST_IDLE) && (mem_Read || mem_Write)));
   assign mem_Readdata = rdata_q;

endmodule
